// File: rtl/paint_pkg.sv
// Shared paint-pipeline types: brush size codes, their pixel
// widths and the default visible screen geometry.
package paint_pkg;

   localparam int H_ACTIVE_DEFAULT = 640;
   localparam int V_ACTIVE_DEFAULT = 480;

   typedef enum logic [1:0] {
      SIZE_4  = 2'b00,
      SIZE_8  = 2'b01,
      SIZE_20 = 2'b10
   } size_t;

   function automatic logic [9:0] brush_width(
      input size_t size
   );
      case (size)
         SIZE_8:  brush_width = 10'd8;
         SIZE_20: brush_width = 10'd20;
         default: brush_width = 10'd4;
      endcase
   endfunction

   function automatic size_t next_size(
      input size_t size
   );
      case (size)
         SIZE_4:  next_size = SIZE_8;
         SIZE_8:  next_size = SIZE_20;
         default: next_size = SIZE_4;
      endcase
   endfunction

endpackage

// File: rtl/cursor_controller_if.sv
// Button inputs and paint-state outputs of the cursor stage.
interface cursor_controller_if;

   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_size;
   logic       btn_layer;
   logic       btn_eraser;
   logic       btn_draw;
   logic       frame_tick;
   logic [9:0] cursor_x;
   logic [9:0] cursor_y;
   logic [1:0] cursor_size;
   logic       draw_layer1_en;
   logic       draw_layer2_en;
   logic       draw_layer3_en;
   logic       eraser;

   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      output btn_size, btn_layer, btn_eraser, btn_draw,
      output frame_tick,
      input  cursor_x, cursor_y, cursor_size,
      input  draw_layer1_en, draw_layer2_en, draw_layer3_en,
      input  eraser
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      input  btn_size, btn_layer, btn_eraser, btn_draw,
      input  frame_tick,
      output cursor_x, cursor_y, cursor_size,
      output draw_layer1_en, draw_layer2_en, draw_layer3_en,
      output eraser
   );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button;
// emits the debounced level and a one-cycle pulse on its rising edge.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         meta  <= raw;
         sync  <= meta;
         press <= 1'b0;
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= sync;
            press <= sync;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cursor_controller.sv
// Cursor stage: debounced buttons drive brush size, layer, eraser
// and frame-paced cursor motion clamped to the visible area.
module cursor_controller
   import paint_pkg::*;
#(
   parameter int H_ACTIVE        = H_ACTIVE_DEFAULT,
   parameter int V_ACTIVE        = V_ACTIVE_DEFAULT,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACCEL_FRAMES    = 16,
   parameter int STEP_SLOW       = 1,
   parameter int STEP_FAST       = 4
) (
   input logic               clk,
   input logic               rst_n,
   cursor_controller_if.slave bus
);

   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_SIZE  = 4;
   localparam int B_LAYER = 5;
   localparam int B_ERASE = 6;
   localparam int B_DRAW  = 7;

   localparam int HW = $clog2(ACCEL_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(ACCEL_FRAMES);

   logic [7:0]    raw;
   logic [7:0]    level;
   logic [7:0]    press;
   logic          unused_press;
   size_t         size;
   size_t         size_nxt;
   logic [2:0]    layer;
   logic          erase;
   logic [2:0]    draw_en;
   logic [9:0]    x;
   logic [9:0]    y;
   logic [9:0]    x_nxt;
   logic [9:0]    y_nxt;
   logic [9:0]    lim_x;
   logic [9:0]    lim_y;
   logic [2:0]    step;
   logic [HW-1:0] hold;
   logic          any_dir;
   logic          tick;

   assign raw = {bus.btn_draw, bus.btn_eraser,
                 bus.btn_layer, bus.btn_size,
                 bus.btn_right, bus.btn_left,
                 bus.btn_down, bus.btn_up};

   for (genvar i = 0; i < 8; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (raw[i]),
         .level(level[i]),
         .press(press[i])
      );
   end

   // Direction and draw buttons act on level only.
   assign unused_press = ^{press[B_DRAW], press[3:0]};

   function automatic logic [9:0] move_axis(
      input logic [9:0] pos,
      input logic       inc,
      input logic       dec,
      input logic [2:0] stp,
      input logic [9:0] lim
   );
      logic signed [10:0] p;
      p = $signed({1'b0, pos});
      if (inc && !dec)
         p = p + $signed({8'd0, stp});
      else if (dec && !inc)
         p = p - $signed({8'd0, stp});
      if (p < 11'sd0)
         p = 11'sd0;
      else if (p > $signed({1'b0, lim}))
         p = $signed({1'b0, lim});
      return p[9:0];
   endfunction

   assign tick    = bus.frame_tick;
   assign any_dir = |level[B_RIGHT:B_UP];

   // New size first, then motion, then one clamp against its width.
   always_comb begin
      size_nxt = press[B_SIZE] ? next_size(size) : size;
      lim_x = 10'(H_ACTIVE) - brush_width(size_nxt);
      lim_y = 10'(V_ACTIVE) - brush_width(size_nxt);
      step  = (hold < HOLD_MAX) ? 3'(STEP_SLOW)
                                : 3'(STEP_FAST);
      x_nxt = move_axis(x, tick & level[B_RIGHT],
                        tick & level[B_LEFT], step, lim_x);
      y_nxt = move_axis(y, tick & level[B_DOWN],
                        tick & level[B_UP], step, lim_y);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size    <= SIZE_4;
         layer   <= 3'b001;
         erase   <= 1'b0;
         draw_en <= 3'b000;
         x       <= '0;
         y       <= '0;
         hold    <= '0;
      end else begin
         size <= size_nxt;
         x    <= x_nxt;
         y    <= y_nxt;
         if (press[B_LAYER])
            layer <= {layer[1:0], layer[2]};
         if (press[B_ERASE])
            erase <= ~erase;
         draw_en <= level[B_DRAW] ? layer : 3'b000;
         if (!any_dir)
            hold <= '0;
         else if (tick && hold != HOLD_MAX)
            hold <= hold + 1'b1;
      end
   end

   assign bus.cursor_x       = x;
   assign bus.cursor_y       = y;
   assign bus.cursor_size    = size;
   assign bus.draw_layer1_en = draw_en[0];
   assign bus.draw_layer2_en = draw_en[1];
   assign bus.draw_layer3_en = draw_en[2];
   assign bus.eraser         = erase;

endmodule
